// File: rtl/serial_pkg.sv
// Shared types and helpers for the 3-wire serial interface blocks.
package serial_pkg;

  typedef enum logic {Idle, Shift} t_serial_target_state;

  // Maps the running bit counter to the word bit it addresses.
  function automatic int unsigned bit_index(input int unsigned ctr,
                                            input int unsigned bits,
                                            input logic        lowbit_first);
    return lowbit_first ? ctr : (bits - 1 - ctr);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with registered
// rise/fall detection on the synchronised level.
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_async,
  output logic out_level,
  output logic out_rise,
  output logic out_fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_async};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign out_level = sync_q[STAGES-1];
  assign out_rise  = rise_q;
  assign out_fall  = fall_q;

endmodule

// File: rtl/serial_target.sv
// Responder end of the 3-wire serial link: oversamples the master clock,
// deserialises incoming words and shifts out a reply word.
module serial_target
  import serial_pkg::*;
#(
  parameter int unsigned BITS                 = 8,
  parameter logic        LOWBIT_FIRST         = 1'b1,
  parameter logic        SERIAL_CLK_INACTIVE  = 1'b1,
  parameter logic        SERIAL_DATA_INACTIVE = 1'b1,
  parameter int unsigned SYNC_STAGES          = 2,
  parameter int unsigned TIMEOUT_CYCLES       = 1000
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_serial,
  output logic            out_serial,
  input  logic [BITS-1:0] in_parallel,
  output logic            out_next_word,
  output logic [BITS-1:0] out_parallel,
  output logic            out_word_valid,
  output logic            out_abort,
  output logic            out_ready
);

  localparam int unsigned CTR_W = $clog2(BITS) + 1;
  localparam int unsigned IDX_W = $clog2(BITS);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BITS - 1);
  localparam logic [IDX_W-1:0] IDX0     = IDX_W'(bit_index(0, BITS, LOWBIT_FIRST));

  logic clk_rise, clk_fall, clk_level_unused;
  logic data_level, data_rise_unused, data_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SERIAL_CLK_INACTIVE)) u_clk_sync (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_serial_clk),
    .out_level(clk_level_unused),
    .out_rise (clk_rise),
    .out_fall (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SERIAL_DATA_INACTIVE)) u_data_sync (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_serial),
    .out_level(data_level),
    .out_rise (data_rise_unused),
    .out_fall (data_fall_unused)
  );

  t_serial_target_state state_q;
  logic [CTR_W-1:0]     bit_ctr_q, bit_ctr_d;
  logic [TMO_W-1:0]     tmo_q;
  logic [BITS-1:0]      tx_q, rx_q, rx_d, par_q;
  logic                 serial_q, valid_q, next_q, abort_q;
  logic                 launch, sample, any_edge;
  logic [IDX_W-1:0]     idx;

  // Launch leaves the idle clock level, sample returns to it.
  assign launch   = SERIAL_CLK_INACTIVE ? clk_fall : clk_rise;
  assign sample   = SERIAL_CLK_INACTIVE ? clk_rise : clk_fall;
  assign any_edge = clk_rise | clk_fall;

  always_comb begin
    idx       = IDX_W'(bit_index(32'(bit_ctr_q), BITS, LOWBIT_FIRST));
    bit_ctr_d = bit_ctr_q + CTR_W'(1);
    rx_d      = rx_q;
    rx_d[idx] = data_level;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= Idle;
      bit_ctr_q <= '0;
      tmo_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      par_q     <= '0;
      serial_q  <= SERIAL_DATA_INACTIVE;
      valid_q   <= 1'b0;
      next_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      next_q  <= 1'b0;
      abort_q <= 1'b0;
      if (any_edge || state_q == Idle) begin
        tmo_q <= '0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      case (state_q)
        Idle: begin
          if (launch) begin
            tx_q      <= in_parallel;
            rx_q      <= '0;
            serial_q  <= in_parallel[IDX0];
            next_q    <= 1'b1;
            bit_ctr_q <= '0;
            state_q   <= Shift;
          end
        end
        Shift: begin
          // Edges take priority; the timeout only fires on an edge-free cycle.
          if (launch) begin
            serial_q <= tx_q[idx];
          end else if (sample) begin
            rx_q <= rx_d;
            if (bit_ctr_q == CTR_LAST) begin
              par_q     <= rx_d;
              valid_q   <= 1'b1;
              bit_ctr_q <= '0;
              serial_q  <= SERIAL_DATA_INACTIVE;
              state_q   <= Idle;
            end else begin
              bit_ctr_q <= bit_ctr_d;
            end
          end else if (tmo_q == TMO_MAX) begin
            abort_q   <= 1'b1;
            rx_q      <= '0;
            bit_ctr_q <= '0;
            serial_q  <= SERIAL_DATA_INACTIVE;
            state_q   <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign out_serial     = serial_q;
  assign out_parallel   = par_q;
  assign out_word_valid = valid_q;
  assign out_next_word  = next_q;
  assign out_abort      = abort_q;
  assign out_ready      = (state_q == Idle);

endmodule
